// File: rtl/cic_decim_prog.sv
// cic_decim_prog
//   N-stage CIC decimator with a run-time decimation ratio. Single clock;
//   in_vld qualifies each input sample, so no divided clocks are needed.
//   Sits between the ADC front end and the digital back end.
//
// Optional build macro: CIC_ROUND_EN
//   defined   : output is rounded (half up) and saturated to OBW bits
//   undefined : output is the top OBW bits of the full-precision result (floor)
//
// Ports
//   clk       in   1      clock, everything on the rising edge
//   res       in   1      synchronous reset, active high
//   in_vld    in   1      in carries a valid sample this cycle
//   in        in   BW     signed input sample
//   rate      in   RW+1   requested decimation ratio, clamped to 2..2**RW
//   out_vld   out  1      one-cycle strobe, out is a new sample
//   out       out  OBW    signed decimated sample, held between strobes
//   rate_act  out  RW+1   ratio in effect for the current group
module cic_decim_prog #(
  parameter int BW  = 11,
  parameter int N   = 3,
  parameter int RW  = 3,
  parameter int OBW = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  in_vld,
  input  logic signed [BW-1:0]  in,
  input  logic        [RW:0]    rate,
  output logic                  out_vld,
  output logic signed [OBW-1:0] out,
  output logic        [RW:0]    rate_act
);

  localparam int OW = BW + N * RW;
  localparam int S  = OW - OBW;
  localparam logic [RW:0] RATE_MIN = (RW+1)'(2);
  localparam logic [RW:0] RATE_MAX = (RW+1)'(2**RW);

  logic        [RW:0]    rate_clamped;
  logic        [RW:0]    cnt;
  logic                  first_pend;
  logic                  dec;
  logic                  dec_q;
  logic signed [OW-1:0]  in_ext;
  logic signed [OW-1:0]  integ    [N];
  logic signed [OW-1:0]  stage_in [N];
  logic        [N-1:0]   stage_vld;
  logic signed [OW-1:0]  comb_q   [N];
  logic signed [OW-1:0]  comb_d   [N];
  logic        [N-1:0]   comb_v;
  logic signed [OW-1:0]  comb_out;

  assign in_ext = {{(OW-BW){in[BW-1]}}, in};

  // Out-of-range ratio requests are pulled back into the legal 2..RMAX window.
  always_comb begin
    rate_clamped = rate;
    if (rate < RATE_MIN)
      rate_clamped = RATE_MIN;
    else if (rate > RATE_MAX)
      rate_clamped = RATE_MAX;
  end

  // cnt starts at 0 with every group, so on the very first valid after reset
  // it cannot match rate_act-1 (rate_act >= 2) and dec stays low.
  assign dec = in_vld && (cnt == rate_act - (RW+1)'(1));

  // Group counter and ratio register. The ratio is only picked up at a group
  // boundary (or the first valid after reset) so a group is never resized.
  always_ff @(posedge clk) begin
    if (res) begin
      cnt        <= '0;
      rate_act   <= RATE_MIN;
      first_pend <= 1'b1;
    end else if (in_vld) begin
      first_pend <= 1'b0;
      if (dec) begin
        cnt      <= '0;
        rate_act <= rate_clamped;
      end else begin
        cnt <= cnt + (RW+1)'(1);
        if (first_pend)
          rate_act <= rate_clamped;
      end
    end
  end

  // Integrator cascade. Each stage adds the registered value of the stage
  // before it; wraparound is intended and cancels in the combs.
  always_ff @(posedge clk) begin
    if (res) begin
      for (int k = 0; k < N; k++)
        integ[k] <= '0;
    end else if (in_vld) begin
      integ[0] <= integ[0] + in_ext;
      for (int k = 1; k < N; k++)
        integ[k] <= integ[k] + integ[k-1];
    end
  end

  // dec_q marks the cycle where the last integrator holds the group result.
  always_ff @(posedge clk) begin
    if (res)
      dec_q <= 1'b0;
    else
      dec_q <= dec;
  end

  // Wiring of comb stage inputs: stage 0 reads the last integrator, the rest
  // read the previous comb stage; valid bits ride along as a shift chain.
  always_comb begin
    stage_in[0]  = integ[N-1];
    stage_vld[0] = dec_q;
    for (int k = 1; k < N; k++) begin
      stage_in[k]  = comb_q[k-1];
      stage_vld[k] = comb_v[k-1];
    end
  end

  // Comb stages with differential delay 1. Output and delay registers only
  // move on their own valid bit, so idle gaps in in_vld do not disturb them.
  always_ff @(posedge clk) begin
    if (res) begin
      comb_v <= '0;
      for (int k = 0; k < N; k++) begin
        comb_q[k] <= '0;
        comb_d[k] <= '0;
      end
    end else begin
      comb_v <= stage_vld;
      for (int k = 0; k < N; k++) begin
        if (stage_vld[k]) begin
          comb_q[k] <= stage_in[k] - comb_d[k];
          comb_d[k] <= stage_in[k];
        end
      end
    end
  end

  assign comb_out = comb_q[N-1];
  assign out_vld  = comb_v[N-1];

`ifdef CIC_ROUND_EN
  if (S == 0) begin : g_pass
    assign out = comb_out;
  end else begin : g_round
    logic signed [OW:0]  rsum;
    logic signed [OBW:0] rq;
    logic                unused_round_lsbs;

    // One extra bit so the rounding constant cannot wrap the largest value.
    assign rsum = {comb_out[OW-1], comb_out} + (OW+1)'(2**(S-1));
    assign rq   = rsum[OW:S];
    assign unused_round_lsbs = ^rsum[S-1:0];

    // rq carries one bit more than out; a disagreeing top pair means overflow.
    always_comb begin
      out = rq[OBW-1:0];
      if (rq[OBW] != rq[OBW-1])
        out = rq[OBW] ? {1'b1, {(OBW-1){1'b0}}} : {1'b0, {(OBW-1){1'b1}}};
    end
  end
`else
  assign out = comb_out[OW-1:S];
  if (S > 0) begin : g_trunc_lsbs
    logic unused_trunc_lsbs;
    assign unused_trunc_lsbs = ^comb_out[S-1:0];
  end
`endif

endmodule

// File: tb/tb_cic_decim_prog.sv
// tb_cic_decim_prog
//   Directed bench for cic_decim_prog with default parameters
//   (BW=11 N=3 RW=3 OBW=16, so OW=20 and 4 LSBs are dropped).
//   Inputs change on the falling edge; a falling-edge monitor logs every
//   out_vld strobe with its cycle number and value.
module tb_cic_decim_prog;

  localparam int BW  = 11;
  localparam int N   = 3;
  localparam int RW  = 3;
  localparam int OBW = 16;

`ifdef CIC_ROUND_EN
  localparam int LSB_OF_8 = 1;
`else
  localparam int LSB_OF_8 = 0;
`endif

  logic                  clk = 1'b0;
  logic                  res;
  logic                  in_vld;
  logic signed [BW-1:0]  in_s;
  logic        [RW:0]    rate;
  logic                  out_vld;
  logic signed [OBW-1:0] out_s;
  logic        [RW:0]    rate_act;

  int cyc    = 0;
  int tests  = 0;
  int failed = 0;
  int strobe_cyc[$];
  int strobe_val[$];

  cic_decim_prog #(.BW(BW), .N(N), .RW(RW), .OBW(OBW)) dut (
    .clk      (clk),
    .res      (res),
    .in_vld   (in_vld),
    .in       (in_s),
    .rate     (rate),
    .out_vld  (out_vld),
    .out      (out_s),
    .rate_act (rate_act)
  );

  always #5 clk = ~clk;

  // Rising-edge count used to time strobes.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe logger.
  always @(negedge clk) begin
    if (out_vld) begin
      strobe_cyc.push_back(cyc);
      strobe_val.push_back(int'(out_s));
    end
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests++;
    if (observed !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Present one input set, then advance one full cycle (falling to falling).
  task automatic applyStimulus(input logic v, input int x, input int r);
    in_vld = v;
    in_s   = BW'(x);
    rate   = (RW+1)'(r);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 0, int'(rate));
  endtask

  task automatic doReset();
    res = 1'b1;
    applyStimulus(1'b0, 0, int'(rate));
    applyStimulus(1'b0, 0, int'(rate));
    res = 1'b0;
    strobe_cyc.delete();
    strobe_val.delete();
  endtask

  function automatic int sval(input int i);
    return (i < strobe_val.size()) ? strobe_val[i] : -999999;
  endfunction

  function automatic int scyc(input int i);
    return (i < strobe_cyc.size()) ? strobe_cyc[i] : -999999;
  endfunction

  initial begin
    int d_cyc;
    int rst_cyc;
    int n_before;
    int n_after;

    res    = 1'b1;
    in_vld = 1'b0;
    in_s   = '0;
    rate   = 4'd8;
    @(negedge clk);

    // 1: reset held with valid input, outputs stay quiet
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 500, 8);
      checkOutput("rst_out", int'(out_s), 0);
      checkOutput("rst_vld", int'(out_vld), 0);
    end
    checkOutput("rst_rate_act", int'(rate_act), 2);
    res = 1'b0;
    applyStimulus(1'b0, 500, 8);
    checkOutput("rate_act_before_first_valid", int'(rate_act), 2);
    strobe_cyc.delete();
    strobe_val.delete();

    // 2: R=8, IN=100 continuous
    d_cyc = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == 7) d_cyc = cyc;
      applyStimulus(1'b1, 100, 8);
      if (i == 0) checkOutput("rate_act_first_valid", int'(rate_act), 8);
    end
    idle(8);
    checkOutput("t2_strobes", strobe_val.size(), 8);
    checkOutput("t2_latency", scyc(0) - d_cyc, N + 1);
    checkOutput("t2_interval", scyc(1) - scyc(0), 8);
    checkOutput("t2_s0", sval(0), 350);
    checkOutput("t2_s1", sval(1), 2450);
    checkOutput("t2_s3", sval(3), 3200);
    checkOutput("t2_s7", sval(7), 3200);

    // 3: R=4 then R=8, IN=-1024 (largest magnitude, no wrap error)
    doReset();
    for (int i = 0; i < 48; i++) applyStimulus(1'b1, -1024, 4);
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, -1024, 8);
    idle(8);
    checkOutput("t3_strobes", strobe_val.size(), 20);
    checkOutput("t3_r4_s10", sval(10), -4096);
    checkOutput("t3_r4_s11", sval(11), -4096);
    checkOutput("t3_r8_s18", sval(18), -32768);
    checkOutput("t3_r8_s19", sval(19), -32768);
    checkOutput("t3_rate_act", int'(rate_act), 8);

    // 4: R=8, in_vld toggling
    doReset();
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 100, 8);
      applyStimulus(1'b0, 100, 8);
    end
    idle(8);
    checkOutput("t4_strobes", strobe_val.size(), 8);
    checkOutput("t4_interval", scyc(5) - scyc(4), 16);
    checkOutput("t4_s0", sval(0), 350);
    checkOutput("t4_s7", sval(7), 3200);

    // 5: ratio 8 -> 4 requested mid-group at cnt=3
    doReset();
    for (int i = 0; i < 27; i++) applyStimulus(1'b1, 100, 8);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 100, 4);
    checkOutput("t5_rate_act_midgroup", int'(rate_act), 8);
    applyStimulus(1'b1, 100, 4);
    checkOutput("t5_rate_act_after_wrap", int'(rate_act), 4);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 100, 4);
    idle(8);
    checkOutput("t5_strobes", strobe_val.size(), 14);
    checkOutput("t5_long_group", scyc(3) - scyc(2), 8);
    checkOutput("t5_first_short", scyc(4) - scyc(3), 4);
    checkOutput("t5_short_group", scyc(5) - scyc(4), 4);
    checkOutput("t5_s13", sval(13), 400);

    // 6: R=2, IN=1, then reset pulse with outputs in flight
    doReset();
    for (int i = 0; i < 21; i++) applyStimulus(1'b1, 1, 2);
    res = 1'b1;
    rst_cyc = cyc;
    applyStimulus(1'b0, 0, 2);
    res = 1'b0;
    idle(8);
    n_before = 0;
    n_after  = 0;
    foreach (strobe_cyc[i]) begin
      if (strobe_cyc[i] > rst_cyc) n_after++;
      else                         n_before++;
    end
    checkOutput("t6_pre_reset_strobes", n_before, 9);
    checkOutput("t6_stale_strobes", n_after, 0);
    checkOutput("t6_pre_s8", sval(8), LSB_OF_8);
    strobe_cyc.delete();
    strobe_val.delete();
    d_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) d_cyc = cyc;
      applyStimulus(1'b1, 1, 2);
    end
    idle(8);
    checkOutput("t6_strobes", strobe_val.size(), 10);
    checkOutput("t6_latency", scyc(0) - d_cyc, N + 1);
    checkOutput("t6_back_to_back", scyc(5) - scyc(4), 2);
    checkOutput("t6_s0", sval(0), 0);
    checkOutput("t6_s9", sval(9), LSB_OF_8);

    // 7: ratio clamping
    doReset();
    applyStimulus(1'b1, 0, 1);
    checkOutput("clamp_low", int'(rate_act), 2);
    doReset();
    applyStimulus(1'b1, 0, 15);
    checkOutput("clamp_high", int'(rate_act), 8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
